// File: rtl/mult_pipe_wrapper.sv
// mult_pipe_wrapper
// Stallable, pipelined WIDTH x WIDTH multiplier with a valid/ready handshake
// on both sides. Each transaction carries its own signed/unsigned mode and a
// sideband tag that comes back unchanged alongside the product.
//
// Pipeline: input capture register -> combinational multiply -> STAGES
// product registers. The last stage drives the out_* ports.
// Total latency is STAGES + 1 clock edges.
//
// A single global stall (result waiting and consumer not ready) freezes
// every register, bubbles included. in_ready is the inverse of that stall.
//
// Optional feature, enabled by defining MULT_PIPE_ACCUM_EN:
//   - adds the in_acc port;
//   - adds a 2*WIDTH-bit running accumulator, updated as each result
//     enters the last stage;
//   - with in_acc=1 the result is acc + product, otherwise it is product;
//   - the accumulator always takes the new result.
//
// Ports:
//   clk          clock, all state on the rising edge
//   rst          asynchronous, active-high reset
//   in_valid     operands/mode/tag valid this cycle
//   in_ready     block accepts a transaction this cycle
//   in_a, in_b   operands, WIDTH bits each
//   in_signed    1 = two's-complement operands, 0 = unsigned
//   in_tag       sideband tag, TAG_W bits
//   in_acc       accumulate request (MULT_PIPE_ACCUM_EN only)
//   out_valid    out_product/out_tag hold a result
//   out_ready    consumer takes the result this cycle
//   out_product  product or accumulated sum, 2*WIDTH bits
//   out_tag      tag of the transaction on out_product
module mult_pipe_wrapper #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  input  logic [TAG_W-1:0]   in_tag,
`ifdef MULT_PIPE_ACCUM_EN
  input  logic               in_acc,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_product,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int PW = 2 * WIDTH;

  logic stall;

  // Input capture register.
  logic [WIDTH-1:0] cap_a_reg;
  logic [WIDTH-1:0] cap_b_reg;
  logic             cap_signed_reg;
  logic [TAG_W-1:0] cap_tag_reg;
  logic             cap_valid_reg;

  logic [PW-1:0] ext_a;
  logic [PW-1:0] ext_b;
  logic [PW-1:0] mult_prod;

  // Product stages and the value each one loads when the pipe advances.
  logic [PW-1:0]    prod_reg  [STAGES];
  logic [TAG_W-1:0] tag_reg   [STAGES];
  logic             valid_reg [STAGES];
  logic [PW-1:0]    prod_src  [STAGES];
  logic [TAG_W-1:0] tag_src   [STAGES];
  logic             valid_src [STAGES];
  logic [PW-1:0]    last_result;

`ifdef MULT_PIPE_ACCUM_EN
  // The accumulate flag is consumed when its result enters the last stage,
  // so only the stages before the last one need to carry it.
  localparam int FW = (STAGES > 1) ? STAGES - 1 : 1;
  logic          cap_acc_reg;
  logic          acc_flag_reg [FW];
  logic          acc_flag_src [STAGES];
  logic [PW-1:0] acc_reg;
  logic [PW-1:0] acc_sum;
`endif

  assign stall       = valid_reg[STAGES-1] && !out_ready;
  assign in_ready    = !stall;
  assign out_valid   = valid_reg[STAGES-1];
  assign out_product = prod_reg[STAGES-1];
  assign out_tag     = tag_reg[STAGES-1];

  // While the pipe is not stalled, in_ready is 1, so every cycle's inputs
  // are captured and in_valid marks whether the slot is real or a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_a_reg      <= '0;
      cap_b_reg      <= '0;
      cap_signed_reg <= 1'b0;
      cap_tag_reg    <= '0;
      cap_valid_reg  <= 1'b0;
    end else if (!stall) begin
      cap_a_reg      <= in_a;
      cap_b_reg      <= in_b;
      cap_signed_reg <= in_signed;
      cap_tag_reg    <= in_tag;
      cap_valid_reg  <= in_valid;
    end
  end

  // Extending both operands to 2*WIDTH and keeping the low 2*WIDTH bits of
  // the product gives the exact result in both signed and unsigned modes.
  assign ext_a = cap_signed_reg ? {{WIDTH{cap_a_reg[WIDTH-1]}}, cap_a_reg}
                                : {{WIDTH{1'b0}}, cap_a_reg};
  assign ext_b = cap_signed_reg ? {{WIDTH{cap_b_reg[WIDTH-1]}}, cap_b_reg}
                                : {{WIDTH{1'b0}}, cap_b_reg};
  assign mult_prod = ext_a * ext_b;

  // Stage links: stage 0 takes the multiplier output, later stages take
  // the preceding stage.
  for (genvar gi = 0; gi < STAGES; gi++) begin : g_link
    if (gi == 0) begin : g_head
      assign prod_src[gi]  = mult_prod;
      assign tag_src[gi]   = cap_tag_reg;
      assign valid_src[gi] = cap_valid_reg;
`ifdef MULT_PIPE_ACCUM_EN
      assign acc_flag_src[gi] = cap_acc_reg;
`endif
    end else begin : g_body
      assign prod_src[gi]  = prod_reg[gi-1];
      assign tag_src[gi]   = tag_reg[gi-1];
      assign valid_src[gi] = valid_reg[gi-1];
`ifdef MULT_PIPE_ACCUM_EN
      assign acc_flag_src[gi] = acc_flag_reg[gi-1];
`endif
    end
  end

`ifdef MULT_PIPE_ACCUM_EN
  assign acc_sum     = acc_reg + prod_src[STAGES-1];
  assign last_result = acc_flag_src[STAGES-1] ? acc_sum : prod_src[STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_acc_reg <= 1'b0;
      acc_reg     <= '0;
      for (int i = 0; i < FW; i++) begin
        acc_flag_reg[i] <= 1'b0;
      end
    end else if (!stall) begin
      cap_acc_reg <= in_acc;
      for (int i = 0; i < STAGES - 1; i++) begin
        acc_flag_reg[i] <= acc_flag_src[i];
      end
      // Bubbles never touch the running sum.
      if (valid_src[STAGES-1]) begin
        acc_reg <= last_result;
      end
    end
  end
`else
  assign last_result = prod_src[STAGES-1];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        prod_reg[i]  <= '0;
        tag_reg[i]   <= '0;
        valid_reg[i] <= 1'b0;
      end
    end else if (!stall) begin
      for (int i = 0; i < STAGES - 1; i++) begin
        prod_reg[i] <= prod_src[i];
      end
      prod_reg[STAGES-1] <= last_result;
      for (int i = 0; i < STAGES; i++) begin
        tag_reg[i]   <= tag_src[i];
        valid_reg[i] <= valid_src[i];
      end
    end
  end

endmodule

// File: tb/tb_mult_pipe_wrapper.sv
// Self-checking bench for mult_pipe_wrapper (WIDTH=32, STAGES=2, TAG_W=4).
// The accumulator scenario is compiled in only when MULT_PIPE_ACCUM_EN is
// defined for both the design and this bench.
module tb_mult_pipe_wrapper;

  localparam int WIDTH  = 32;
  localparam int STAGES = 2;
  localparam int TAG_W  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        in_signed = 1'b0;
  logic [3:0]  in_tag = '0;
  logic        in_acc = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_product;
  logic [3:0]  out_tag;

  int checks = 0;
  int passes = 0;

  // Reference model state: expected results in acceptance order.
  logic [63:0] exp_q[$];
  logic [3:0]  tag_q[$];
  logic [63:0] acc_m = '0;

  // Per-cycle observations captured by step().
  logic        in_fire, out_fire, obs_valid, obs_ready;
  logic [63:0] obs_prod;
  logic [3:0]  obs_tag;

  always #5 clk = ~clk;

  mult_pipe_wrapper #(.WIDTH(WIDTH), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_signed  (in_signed),
    .in_tag     (in_tag),
`ifdef MULT_PIPE_ACCUM_EN
    .in_acc     (in_acc),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_product(out_product),
    .out_tag    (out_tag)
  );

  function automatic logic [63:0] model_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic s);
    longint sa, sb;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  // Drive one cycle's inputs in the low clock phase, then sample outputs
  // and record accepted transactions in the reference model.
  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b,
                      input logic s, input logic [3:0] t, input logic acc,
                      input logic ordy);
    logic [63:0] p;
    @(negedge clk);
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_signed = s;
    in_tag    = t;
    in_acc    = acc;
    out_ready = ordy;
    #1;
    obs_valid = out_valid;
    obs_ready = in_ready;
    obs_prod  = out_product;
    obs_tag   = out_tag;
    in_fire   = in_valid && in_ready;
    out_fire  = out_valid && out_ready;
    if (in_fire) begin
      p = model_mul(a, b, s);
`ifdef MULT_PIPE_ACCUM_EN
      if (acc) p = acc_m + p;
      acc_m = p;
`endif
      exp_q.push_back(p);
      tag_q.push_back(t);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    tag_q.delete();
    acc_m = '0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b required 0", out_valid); else passes++;
    checks++; if (out_product !== 64'd0) $display("FAIL reset_out_product: got %h required 0", out_product); else passes++;
    checks++; if (out_tag !== 4'd0) $display("FAIL reset_out_tag: got %h required 0", out_tag); else passes++;
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b required 1", in_ready); else passes++;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    tag_q.delete();
    acc_m = '0;
  endtask

  task automatic test_directed();
    logic [31:0] da[5] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] db[5] = '{32'h0000_0007, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h0000_0001};
    logic        ds[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [3:0]  dt[5] = '{4'h5, 4'h6, 4'h7, 4'h8, 4'h9};
    logic [63:0] dp[5] = '{64'hFFFF_FFFF_FFFF_FFEB, 64'hFFFF_FFFE_0000_0001,
                           64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000,
                           64'hFFFF_FFFF_8000_0000};
    do_reset();
    for (int j = 0; j < 9; j++) begin
      if (j < 5) step(1'b1, da[j], db[j], ds[j], dt[j], 1'b0, 1'b1);
      else       step(1'b0, 32'd0, 32'd0, 1'b0, 4'd0, 1'b0, 1'b1);
      if (j < 5) begin
        checks++; if (obs_ready !== 1'b1) $display("FAIL dir_in_ready[%0d]: got %b required 1", j, obs_ready); else passes++;
      end
      if (j < 3 || j == 8) begin
        checks++; if (obs_valid !== 1'b0) $display("FAIL dir_idle_valid[%0d]: got %b required 0", j, obs_valid); else passes++;
      end else begin
        $display("dir   result %0d: product=%h tag=%h valid=%b", j - 3, obs_prod, obs_tag, obs_valid);
        checks++; if (obs_valid !== 1'b1) $display("FAIL dir_valid[%0d]: got %b required 1", j - 3, obs_valid); else passes++;
        checks++; if (obs_prod !== dp[j-3]) $display("FAIL dir_product[%0d]: got %h required %h", j - 3, obs_prod, dp[j-3]); else passes++;
        checks++; if (obs_tag !== dt[j-3]) $display("FAIL dir_tag[%0d]: got %h required %h", j - 3, obs_tag, dt[j-3]); else passes++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] ep;
    do_reset();
    for (int j = 0; j < 13; j++) begin
      if (j < 8) step(1'b1, 32'(j + 1), 32'(j + 2), 1'b0, 4'(j + 1), 1'b0, 1'b1);
      else       step(1'b0, 32'd0, 32'd0, 1'b0, 4'd0, 1'b0, 1'b1);
      if (j < 8) begin
        checks++; if (obs_ready !== 1'b1) $display("FAIL b2b_in_ready[%0d]: got %b required 1", j, obs_ready); else passes++;
      end
      if (j >= 3 && j <= 10) begin
        ep = 64'((j - 2) * (j - 1));
        $display("b2b   result %0d: product=%0d tag=%0d valid=%b", j - 3, obs_prod, obs_tag, obs_valid);
        checks++; if (obs_valid !== 1'b1) $display("FAIL b2b_valid[%0d]: got %b required 1", j - 3, obs_valid); else passes++;
        checks++; if (obs_prod !== ep) $display("FAIL b2b_product[%0d]: got %0d required %0d", j - 3, obs_prod, ep); else passes++;
        checks++; if (obs_tag !== 4'(j - 2)) $display("FAIL b2b_tag[%0d]: got %0d required %0d", j - 3, obs_tag, j - 2); else passes++;
      end else begin
        checks++; if (obs_valid !== 1'b0) $display("FAIL b2b_idle_valid[%0d]: got %b required 0", j, obs_valid); else passes++;
      end
    end
  endtask

  task automatic test_stall();
    int idx = 0;
    int rc = 0;
    logic ordy;
    logic [63:0] ep;
    do_reset();
    for (int j = 0; j < 40; j++) begin
      ordy = !(j >= 4 && j <= 8);
      if (idx < 8) step(1'b1, 32'(idx + 1), 32'(idx + 2), 1'b0, 4'(idx + 1), 1'b0, ordy);
      else         step(1'b0, 32'd0, 32'd0, 1'b0, 4'd0, 1'b0, ordy);
      if (in_fire) idx++;
      if (j >= 4 && j <= 8) begin
        // Second result (2*3) is parked on the output during the stall.
        checks++; if (obs_ready !== 1'b0) $display("FAIL stall_in_ready[%0d]: got %b required 0", j, obs_ready); else passes++;
        checks++; if (obs_valid !== 1'b1) $display("FAIL stall_valid[%0d]: got %b required 1", j, obs_valid); else passes++;
        checks++; if (obs_prod !== 64'd6) $display("FAIL stall_hold_product[%0d]: got %0d required 6", j, obs_prod); else passes++;
        checks++; if (obs_tag !== 4'd2) $display("FAIL stall_hold_tag[%0d]: got %0d required 2", j, obs_tag); else passes++;
      end
      if (out_fire) begin
        $display("stall result %0d: product=%0d tag=%0d", rc, obs_prod, obs_tag);
        checks++;
        if (rc >= 8) begin
          $display("FAIL stall_extra_result: got result #%0d required at most 8", rc + 1);
        end else begin
          passes++;
          ep = 64'((rc + 1) * (rc + 2));
          checks++; if (obs_prod !== ep) $display("FAIL stall_product[%0d]: got %0d required %0d", rc, obs_prod, ep); else passes++;
          checks++; if (obs_tag !== 4'(rc + 1)) $display("FAIL stall_tag[%0d]: got %0d required %0d", rc, obs_tag, rc + 1); else passes++;
        end
        rc++;
      end
    end
    checks++; if (rc != 8) $display("FAIL stall_result_count: got %0d required 8", rc); else passes++;
    checks++; if (idx != 8) $display("FAIL stall_accept_count: got %0d required 8", idx); else passes++;
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int j = 0; j < 3; j++) begin
      step(1'b1, $urandom() | 32'd1, $urandom() | 32'd1, 1'($urandom()), 4'(j + 1), 1'b0, 1'b0);
    end
    step(1'b0, 32'd0, 32'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    checks++; if (obs_valid !== 1'b1) $display("FAIL arst_pre_valid: got %b required 1", obs_valid); else passes++;
    // Mid low phase: no clock edge occurs before the checks below.
    #2;
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL arst_out_valid: got %b required 0", out_valid); else passes++;
    checks++; if (out_product !== 64'd0) $display("FAIL arst_out_product: got %h required 0", out_product); else passes++;
    checks++; if (out_tag !== 4'd0) $display("FAIL arst_out_tag: got %h required 0", out_tag); else passes++;
    checks++; if (in_ready !== 1'b1) $display("FAIL arst_in_ready: got %b required 1", in_ready); else passes++;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    tag_q.delete();
    acc_m = '0;
    for (int j = 0; j < 10; j++) begin
      step(1'b0, 32'd0, 32'd0, 1'b0, 4'd0, 1'b0, 1'b1);
      checks++; if (obs_valid !== 1'b0) $display("FAIL arst_stale_valid[%0d]: got %b required 0", j, obs_valid); else passes++;
    end
  endtask

  task automatic test_random();
    logic        prev_stalled = 1'b0;
    logic [63:0] prev_prod = '0;
    logic [3:0]  prev_tag = '0;
    logic [63:0] ep;
    logic [3:0]  et;
    int n = 0;
    do_reset();
    for (int j = 0; j < 160; j++) begin
      if (j < 140)
        step(1'($urandom_range(0, 3) != 0), pick_operand(), pick_operand(),
             1'($urandom()), 4'($urandom()), 1'($urandom()), 1'($urandom_range(0, 2) != 0));
      else
        step(1'b0, 32'd0, 32'd0, 1'b0, 4'd0, 1'b0, 1'b1);
      if (prev_stalled) begin
        checks++;
        if (obs_valid !== 1'b1 || obs_prod !== prev_prod || obs_tag !== prev_tag)
          $display("FAIL rnd_hold[%0d]: got v=%b %h/%h required v=1 %h/%h", j, obs_valid, obs_prod, obs_tag, prev_prod, prev_tag);
        else passes++;
      end
      if (out_fire) begin
        checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL rnd_unexpected_result: got %h tag %h required no result", obs_prod, obs_tag);
        end else begin
          passes++;
          ep = exp_q.pop_front();
          et = tag_q.pop_front();
          $display("rnd   result %0d: product=%h tag=%h", n, obs_prod, obs_tag);
          checks++; if (obs_prod !== ep) $display("FAIL rnd_product[%0d]: got %h required %h", n, obs_prod, ep); else passes++;
          checks++; if (obs_tag !== et) $display("FAIL rnd_tag[%0d]: got %h required %h", n, obs_tag, et); else passes++;
          n++;
        end
      end
      prev_stalled = obs_valid && !out_ready;
      prev_prod    = obs_prod;
      prev_tag     = obs_tag;
    end
    checks++; if (exp_q.size() != 0) $display("FAIL rnd_drain: got %0d outstanding required 0", exp_q.size()); else passes++;
  endtask

`ifdef MULT_PIPE_ACCUM_EN
  task automatic test_accum();
    logic [63:0] exp_acc[3] = '{64'd6, 64'd26, 64'd1};
    int rc = 0;
    do_reset();
    for (int j = 0; j < 11; j++) begin
      case (j)
        0: step(1'b1, 32'd2, 32'd3, 1'b0, 4'd1, 1'b0, 1'b1);
        1: step(1'b1, 32'd4, 32'd5, 1'b0, 4'd2, 1'b1, 1'b1);
        2: step(1'b1, 32'd1, 32'd1, 1'b0, 4'd3, 1'b0, 1'b1);
        default: step(1'b0, 32'd0, 32'd0, 1'b0, 4'd0, 1'b0, 1'b1);
      endcase
      if (out_fire) begin
        $display("acc   result %0d: product=%0d tag=%0d", rc, obs_prod, obs_tag);
        checks++;
        if (rc >= 3) begin
          $display("FAIL acc_extra_result: got result #%0d required at most 3", rc + 1);
        end else begin
          passes++;
          checks++; if (obs_prod !== exp_acc[rc]) $display("FAIL acc_product[%0d]: got %0d required %0d", rc, obs_prod, exp_acc[rc]); else passes++;
        end
        rc++;
      end
    end
    checks++; if (rc != 3) $display("FAIL acc_result_count: got %0d required 3", rc); else passes++;
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall();
    test_async_reset();
    test_random();
`ifdef MULT_PIPE_ACCUM_EN
    test_accum();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
